// File: rtl/program_loader.sv
// Byte-stream program loader: packs big-endian words into instruction memory and holds the CPU until done.
// Optional trailing XOR checksum byte is enabled with LOADER_CKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start, CPU held
// LEN_HI | accepting high byte of the word count
// LEN_LO | accepting low byte of the word count, range check
// DATA   | accepting payload bytes of the current word
// WRITE  | one-cycle memory write of the assembled word
// CKSUM  | accepting checksum byte (LOADER_CKSUM_EN only)
// DONE   | program loaded, CPU released
// ERROR  | load aborted, CPU held
module program_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_count_o
);

`ifdef LOADER_CKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR, S_CKSUM
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_e;
`endif

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_e              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [15:0]         len_q, len_d;
    logic [23:0]         shift_q, shift_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
`ifdef LOADER_CKSUM_EN
    logic [7:0]          cks_q, cks_d;
`endif

    logic                accept;
    logic [15:0]         len_in;
    logic                last_word;
    state_e              payload_end;

    assign accept    = in_valid_i && in_ready_o;
    assign len_in    = {len_hi_q, in_data_i};
    assign last_word = (17'(count_q) + 17'd1) == {1'b0, len_q};
`ifdef LOADER_CKSUM_EN
    assign payload_end = S_CKSUM;
`else
    assign payload_end = S_DONE;
`endif

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        count_d    = count_q;
`ifdef LOADER_CKSUM_EN
        cks_d      = cks_q;
`endif
        in_ready_o = 1'b0;
        mem_we_o   = 1'b0;
        cpu_hold_o = 1'b1;
        done_o     = 1'b0;
        error_o    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                done_o     = (state_q == S_DONE);
                cpu_hold_o = (state_q != S_DONE);
                error_o    = (state_q == S_ERROR);
                if (start_i) begin
                    state_d = S_LEN_HI;
                    count_d = '0;
                    addr_d  = '0;
`ifdef LOADER_CKSUM_EN
                    cks_d   = '0;
`endif
                end
            end
            S_LEN_HI: begin
                in_ready_o = 1'b1;
                if (accept) begin
                    len_hi_d = in_data_i;
`ifdef LOADER_CKSUM_EN
                    cks_d    = cks_q ^ in_data_i;
`endif
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                in_ready_o = 1'b1;
                if (accept) begin
                    len_d      = len_in;
                    byte_idx_d = '0;
`ifdef LOADER_CKSUM_EN
                    cks_d      = cks_q ^ in_data_i;
`endif
                    if ({1'b0, len_in} > MAX_WORDS)
                        state_d = S_ERROR;
                    else if (len_in == 16'd0)
                        state_d = payload_end;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                in_ready_o = 1'b1;
                if (accept) begin
`ifdef LOADER_CKSUM_EN
                    cks_d = cks_q ^ in_data_i;
`endif
                    if (byte_idx_q == 2'd3) begin
                        wdata_d    = {shift_q, in_data_i};
                        byte_idx_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        shift_d    = {shift_q[15:0], in_data_i};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                mem_we_o = 1'b1;
                count_d  = count_q + (ADDR_W+1)'(1);
                // address stays on the final word so a full-size program never wraps to 0
                if (last_word) begin
                    state_d = payload_end;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CKSUM_EN
            S_CKSUM: begin
                in_ready_o = 1'b1;
                if (accept)
                    state_d = (cks_q == in_data_i) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            count_q    <= '0;
`ifdef LOADER_CKSUM_EN
            cks_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
`ifdef LOADER_CKSUM_EN
            cks_q      <= cks_d;
`endif
        end
    end

    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign word_count_o = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader; expected writes come from a byte-stream reference model.
module tb_program_loader;
    localparam int ADDR_W = 8;
`ifdef LOADER_CKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, mem_we, cpu_hold, done, error;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   word_count;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(in_ready), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .cpu_hold_o(cpu_hold),
        .done_o(done), .error_o(error), .word_count_o(word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [ADDR_W-1:0] mon_a;
    logic [31:0]       mon_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the next expected word
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            if (exp_addr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h want no write", mem_addr, mem_wdata);
            end else begin
                mon_a = exp_addr.pop_front();
                mon_d = exp_data.pop_front();
                check("write_addr", 64'(mem_addr), 64'(mon_a));
                check("write_data", 64'(mem_wdata), 64'(mon_d));
            end
            check("in_ready_in_write", 64'(in_ready), 64'(0));
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input int gap, output bit ok);
        int cnt;
        ok = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        cnt = 0;
        while (!ok && cnt < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
            cnt++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL byte_accept: got no in_ready want accept of %0h", b);
        end
    endtask

    task automatic gen_payload(input int n, output logic [7:0] pl[$]);
        pl = {};
        for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
    endtask

    // reference: length header, big-endian words at consecutive addresses, XOR checksum of all bytes
    task automatic run_load(input int n, input logic [7:0] pl[$], input int glo, input int ghi,
                            input bit do_start, input logic [7:0] ck_mask);
        logic [7:0] s[$];
        logic [7:0] ck;
        bit ok, expect_err;
        int cyc;
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(ADDR_W'(i));
            exp_data.push_back({pl[4*i], pl[4*i+1], pl[4*i+2], pl[4*i+3]});
            for (int k = 0; k < 4; k++) s.push_back(pl[4*i+k]);
        end
        ck = 8'h00;
        foreach (s[k]) ck = ck ^ s[k];
        if (CKSUM_EN) s.push_back(ck ^ ck_mask);
        expect_err = CKSUM_EN && (ck_mask != 8'h00);
        if (do_start) pulse_start();
        foreach (s[k]) begin
            drive_byte(s[k], int'($urandom_range(ghi, glo)), ok);
            if (!ok) return;
        end
        cyc = 0;
        while (!(done || error) && cyc < 30000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 30000) begin
            total++;
            bad++;
            $display("FAIL load_timeout: got no done/error want completion n=%0d", n);
            return;
        end
        check("end_done", 64'(done), 64'(!expect_err));
        check("end_error", 64'(error), 64'(expect_err));
        check("end_cpu_hold", 64'(cpu_hold), 64'(expect_err));
        check("end_word_count", 64'(word_count), 64'(n));
        check("pending_writes", 64'(exp_addr.size()), 64'(0));
    endtask

    logic [7:0] pl[$];
    bit ok;

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_cpu_hold", 64'(cpu_hold), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_word_count", 64'(word_count), 64'(0));
        reset = 1'b0;

        repeat (10) @(posedge clk);
        #1;
        check("idle_cpu_hold", 64'(cpu_hold), 64'(1));
        check("idle_in_ready", 64'(in_ready), 64'(0));
        check("idle_done", 64'(done), 64'(0));
        check("idle_error", 64'(error), 64'(0));

        pl = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00};
        run_load(2, pl, 0, 0, 1'b1, 8'h00);
        run_load(2, pl, 3, 3, 1'b1, 8'h00);

        // oversize length aborts straight after the low length byte
        pulse_start();
        drive_byte(8'h01, 0, ok);
        drive_byte(8'h01, 0, ok);
        check("len_err_error", 64'(error), 64'(1));
        check("len_err_cpu_hold", 64'(cpu_hold), 64'(1));
        check("len_err_in_ready", 64'(in_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        pulse_start();
        check("restart_error", 64'(error), 64'(0));
        check("restart_in_ready", 64'(in_ready), 64'(1));
        gen_payload(1, pl);
        run_load(1, pl, 0, 1, 1'b0, 8'h00);

        // reset in the middle of the second word
        pulse_start();
        drive_byte(8'h00, 0, ok);
        drive_byte(8'h03, 0, ok);
        exp_addr.push_back('0);
        exp_data.push_back(32'h11223344);
        drive_byte(8'h11, 0, ok);
        drive_byte(8'h22, 0, ok);
        drive_byte(8'h33, 0, ok);
        drive_byte(8'h44, 1, ok);
        drive_byte(8'hAA, 0, ok);
        drive_byte(8'hBB, 0, ok);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        check("midrst_mem_addr", 64'(mem_addr), 64'(0));
        check("midrst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("midrst_cpu_hold", 64'(cpu_hold), 64'(1));
        check("midrst_word_count", 64'(word_count), 64'(0));
        check("midrst_pending", 64'(exp_addr.size()), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        gen_payload(3, pl);
        run_load(3, pl, 0, 2, 1'b1, 8'h00);

        pl = {};
        run_load(0, pl, 0, 0, 1'b1, 8'h00);

        for (int t = 0; t < 8; t++) begin
            int n;
            n = int'($urandom_range(12, 1));
            gen_payload(n, pl);
            run_load(n, pl, 0, 3, 1'b1, 8'h00);
        end

        gen_payload(256, pl);
        run_load(256, pl, 0, 1, 1'b1, 8'h00);

`ifdef LOADER_CKSUM_EN
        pl = '{8'hFC, 8'h00, 8'h00, 8'h00};
        run_load(1, pl, 0, 0, 1'b1, 8'h00);
        run_load(1, pl, 0, 0, 1'b1, 8'h07);
        gen_payload(4, pl);
        run_load(4, pl, 0, 2, 1'b1, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
